// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle processor control unit: FSM states,
// instruction IDs, datapath select codes and ID classification helpers.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [31:0] ID_ADD     = 32'd1;
  localparam logic [31:0] ID_SUB     = 32'd2;
  localparam logic [31:0] ID_ADDU    = 32'd3;
  localparam logic [31:0] ID_SUBU    = 32'd4;
  localparam logic [31:0] ID_ADDI    = 32'd5;
  localparam logic [31:0] ID_ADDIU   = 32'd6;
  localparam logic [31:0] ID_AND     = 32'd7;
  localparam logic [31:0] ID_OR      = 32'd8;
  localparam logic [31:0] ID_ANDI    = 32'd9;
  localparam logic [31:0] ID_ORI     = 32'd10;
  localparam logic [31:0] ID_SLL     = 32'd11;
  localparam logic [31:0] ID_SRL     = 32'd12;
  localparam logic [31:0] ID_LW      = 32'd13;
  localparam logic [31:0] ID_SW      = 32'd14;
  localparam logic [31:0] ID_BEQ     = 32'd15;
  localparam logic [31:0] ID_BNE     = 32'd16;
  localparam logic [31:0] ID_BLT     = 32'd17;
  localparam logic [31:0] ID_BGE     = 32'd18;
  localparam logic [31:0] ID_BLE     = 32'd19;
  localparam logic [31:0] ID_BGT     = 32'd20;
  localparam logic [31:0] ID_J       = 32'd21;
  localparam logic [31:0] ID_JR      = 32'd22;
  localparam logic [31:0] ID_JAL     = 32'd23;
  localparam logic [31:0] ID_SLT     = 32'd24;
  localparam logic [31:0] ID_SLTI    = 32'd25;
  localparam logic [31:0] ID_SYSCALL = 32'd26;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;

  localparam logic [1:0] PC_SEL_OFFSET = 2'd0;
  localparam logic [1:0] PC_SEL_JIMM   = 2'd1;
  localparam logic [1:0] PC_SEL_REG    = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  function automatic logic is_legal_id(input logic [31:0] id);
    return (id >= ID_ADD) && (id <= ID_SYSCALL);
  endfunction

  // Register/immediate ALU ops that finish through WB without touching memory.
  function automatic logic is_alu_id(input logic [31:0] id);
    return ((id >= ID_ADD) && (id <= ID_SRL)) || (id == ID_SLT) || (id == ID_SLTI);
  endfunction

  function automatic logic is_branch_id(input logic [31:0] id);
    return (id >= ID_BEQ) && (id <= ID_BGT);
  endfunction

endpackage

// File: rtl/ctrl_alu_map.sv
// Combinational map from instruction ID to ALU operation and operand-B source.
module ctrl_alu_map
  import ctrl_pkg::*;
(
  input  logic [31:0] id,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm
);

  always_comb begin
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    case (id)
      ID_ADD, ID_ADDU:  alu_op = ALU_ADD;
      ID_ADDI, ID_ADDIU: begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
      end
      ID_SUB, ID_SUBU:  alu_op = ALU_SUB;
      ID_AND:           alu_op = ALU_AND;
      ID_ANDI: begin
        alu_op      = ALU_AND;
        alu_src_imm = 1'b1;
      end
      ID_OR:            alu_op = ALU_OR;
      ID_ORI: begin
        alu_op      = ALU_OR;
        alu_src_imm = 1'b1;
      end
      ID_SLL: begin
        alu_op      = ALU_SLL;
        alu_src_imm = 1'b1;
      end
      ID_SRL: begin
        alu_op      = ALU_SRL;
        alu_src_imm = 1'b1;
      end
      ID_SLT:           alu_op = ALU_SLT;
      ID_SLTI: begin
        alu_op      = ALU_SLT;
        alu_src_imm = 1'b1;
      end
      // Loads and stores add the offset immediate to the base register.
      ID_LW, ID_SW: begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
      end
      default: begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences fetch/decode/exec/mem/wb, handles
// syscalls, counts retired instructions and halts on exit or illegal ID.
module proc_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int RA_REG   = 31,
  parameter int SYS_EXIT = 10,
  parameter int SYS_DISP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] id,
  input  logic        br_taken,
  input  logic [31:0] sys_sel,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        dst_ra,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        disp_valid,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  // The link register index is applied by the datapath; only its range is checked here.
  if ((RA_REG < 0) || (RA_REG > 31)) begin : g_bad_ra_reg
    $error("RA_REG must be a register index in 0..31");
  end

  state_t      state_reg, state_next;
  logic        illegal_reg, illegal_next;
  logic [31:0] retired_reg;
  logic        retire;
  logic [2:0]  map_alu_op;
  logic        map_alu_src_imm;
  logic        is_lw;

  ctrl_alu_map u_alu_map (
    .id          (id),
    .alu_op      (map_alu_op),
    .alu_src_imm (map_alu_src_imm)
  );

  assign is_lw = (id == ID_LW);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (retire) begin
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    pc_sel       = PC_SEL_OFFSET;
    reg_we       = 1'b0;
    wb_sel       = WB_SEL_ALU;
    dst_ra       = 1'b0;
    alu_op       = map_alu_op;
    alu_src_imm  = map_alu_src_imm;
    dmem_re      = 1'b0;
    dmem_we      = 1'b0;
    disp_valid   = 1'b0;
    halted       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (is_legal_id(id)) begin
          state_next = ST_EXEC;
        end else begin
          illegal_next = 1'b1;
          state_next   = ST_HALT;
        end
      end

      ST_EXEC: begin
        if (is_alu_id(id)) begin
          state_next = ST_WB;
        end else if ((id == ID_LW) || (id == ID_SW)) begin
          state_next = ST_MEM;
        end else if (is_branch_id(id)) begin
          alu_op     = ALU_SUB;
          pc_load    = br_taken;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (id == ID_J) begin
          pc_load    = 1'b1;
          pc_sel     = PC_SEL_JIMM;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (id == ID_JR) begin
          pc_load    = 1'b1;
          pc_sel     = PC_SEL_REG;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (id == ID_JAL) begin
          // Link value is the PC already advanced during FETCH.
          pc_load    = 1'b1;
          pc_sel     = PC_SEL_JIMM;
          reg_we     = 1'b1;
          wb_sel     = WB_SEL_LINK;
          dst_ra     = 1'b1;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (id == ID_SYSCALL) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
          if (sys_sel == 32'(SYS_DISP)) begin
            disp_valid = 1'b1;
          end else if (sys_sel == 32'(SYS_EXIT)) begin
            state_next = ST_HALT;
          end
        end else begin
          // ID changed after DECODE to something unusable: stop rather than guess.
          illegal_next = 1'b1;
          state_next   = ST_HALT;
        end
      end

      ST_MEM: begin
        dmem_re = is_lw;
        dmem_we = !is_lw;
        if (dmem_ready) begin
          if (is_lw) begin
            state_next = ST_WB;
          end else begin
            retire     = 1'b1;
            state_next = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        reg_we     = 1'b1;
        wb_sel     = is_lw ? WB_SEL_MEM : WB_SEL_ALU;
        retire     = 1'b1;
        state_next = ST_FETCH;
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign illegal = illegal_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Randomized self-checking bench for proc_ctrl_fsm; expectations come from a
// per-instruction timing/strobe model derived from the instruction classes.
module tb_proc_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] id;
  logic        br_taken;
  logic [31:0] sys_sel;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        dst_ra;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic        dmem_re;
  logic        dmem_we;
  logic        disp_valid;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_retired;
  int          ref_op  [27];
  bit          ref_imm [27];

  proc_ctrl_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .id          (id),
    .br_taken    (br_taken),
    .sys_sel     (sys_sel),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .ir_load     (ir_load),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_sel      (pc_sel),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .dst_ra      (dst_ra),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .dmem_re     (dmem_re),
    .dmem_we     (dmem_we),
    .disp_valid  (disp_valid),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU table: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SLT.
  task automatic init_ref();
    for (int i = 0; i < 27; i++) begin
      ref_op[i]  = 0;
      ref_imm[i] = 1'b0;
    end
    ref_imm[5] = 1; ref_imm[6] = 1;
    ref_op[2] = 1; ref_op[4] = 1;
    ref_op[7] = 2; ref_op[9] = 2; ref_imm[9] = 1;
    ref_op[8] = 3; ref_op[10] = 3; ref_imm[10] = 1;
    ref_op[11] = 4; ref_imm[11] = 1;
    ref_op[12] = 5; ref_imm[12] = 1;
    ref_op[24] = 6; ref_op[25] = 6; ref_imm[25] = 1;
    ref_imm[13] = 1; ref_imm[14] = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_retired = '0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle; iw/dw are memory wait cycles.
  task automatic run_instr(input int unsigned iid, input bit br, input logic [31:0] sys,
                           input int iw, input int dw);
    bit lw_i, sw_i, br_i, j_i, jr_i, jal_i, sys_i, alu_i, bad, exp_halt, mem_i;
    int n, ms;
    int n_req, n_irl, n_pci, n_pcl, n_we, n_dst, n_re, n_wr, n_disp, irl_cyc;
    int got_pcsel, got_wbsel, got_op, got_imm;
    int e_pcl, e_pcsel, e_we, e_wbsel, e_op, e_imm;
    lw_i  = (iid == 13);
    sw_i  = (iid == 14);
    br_i  = (iid >= 15 && iid <= 20);
    j_i   = (iid == 21);
    jr_i  = (iid == 22);
    jal_i = (iid == 23);
    sys_i = (iid == 26);
    alu_i = (iid >= 1 && iid <= 12) || iid == 24 || iid == 25;
    bad   = (iid == 0 || iid > 26);
    mem_i = lw_i || sw_i;
    exp_halt = bad || (sys_i && sys == 32'd10);
    n  = iw + (bad ? 2 : lw_i ? 5 + dw : sw_i ? 4 + dw : alu_i ? 4 : 3);
    ms = iw + 3;
    e_pcl   = ((br_i && br) || j_i || jr_i || jal_i) ? 1 : 0;
    e_pcsel = (j_i || jal_i) ? 1 : jr_i ? 2 : 0;
    e_we    = (alu_i || lw_i || jal_i) ? 1 : 0;
    e_wbsel = lw_i ? 1 : jal_i ? 2 : 0;
    e_op    = br_i ? 1 : (bad ? 0 : ref_op[iid]);
    e_imm   = bad ? 0 : int'(ref_imm[iid]);
    n_req = 0; n_irl = 0; n_pci = 0; n_pcl = 0; n_we = 0; n_dst = 0;
    n_re = 0; n_wr = 0; n_disp = 0; irl_cyc = -1;
    got_pcsel = -1; got_wbsel = -1; got_op = -1; got_imm = -1;
    for (int k = 0; k < n; k++) begin
      id = iid; br_taken = br; sys_sel = sys;
      start = 1'($urandom % 2);
      imem_ready = (k < iw) ? 1'b0 : (k == iw) ? 1'b1 : 1'($urandom % 2);
      if (mem_i && k >= ms && k <= ms + dw) dmem_ready = (k == ms + dw);
      else dmem_ready = 1'($urandom % 2);
      #1;
      n_req += int'(imem_req); n_pci += int'(pc_inc); n_re += int'(dmem_re);
      n_wr += int'(dmem_we); n_disp += int'(disp_valid); n_dst += int'(dst_ra);
      if (ir_load) begin n_irl++; irl_cyc = k; end
      if (pc_load) begin n_pcl++; got_pcsel = int'(pc_sel); end
      if (reg_we) begin n_we++; got_wbsel = int'(wb_sel); end
      if (k == iw + 2) begin got_op = int'(alu_op); got_imm = int'(alu_src_imm); end
      @(negedge clk);
    end
    start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    if (!bad) exp_retired = exp_retired + 32'd1;
    #1;
    $display("[TB] instr id=%0d br=%0d sys=%0d iw=%0d dw=%0d cycles=%0d", iid, br, sys, iw, dw, n);
    tests_run++;
    if (n_req !== iw + 1 || n_irl !== 1 || n_pci !== 1 || irl_cyc !== iw) begin
      tests_failed++;
      $display("FAIL fetch id=%0d req=%0d irl=%0d pci=%0d irl_cyc=%0d, exp req=%0d irl=1 pci=1 irl_cyc=%0d",
               iid, n_req, n_irl, n_pci, irl_cyc, iw + 1, iw);
    end
    tests_run++;
    if (n_pcl !== e_pcl || (e_pcl == 1 && got_pcsel !== e_pcsel)) begin
      tests_failed++;
      $display("FAIL pc_load id=%0d got %0d sel=%0d, exp %0d sel=%0d", iid, n_pcl, got_pcsel, e_pcl, e_pcsel);
    end
    tests_run++;
    if (n_we !== e_we || (e_we == 1 && got_wbsel !== e_wbsel) || n_dst !== int'(jal_i)) begin
      tests_failed++;
      $display("FAIL reg_we id=%0d got %0d wb_sel=%0d dst_ra=%0d, exp %0d wb_sel=%0d dst_ra=%0d",
               iid, n_we, got_wbsel, n_dst, e_we, e_wbsel, jal_i);
    end
    tests_run++;
    if (n_re !== (lw_i ? dw + 1 : 0) || n_wr !== (sw_i ? dw + 1 : 0)) begin
      tests_failed++;
      $display("FAIL dmem id=%0d re=%0d we=%0d, exp re=%0d we=%0d",
               iid, n_re, n_wr, lw_i ? dw + 1 : 0, sw_i ? dw + 1 : 0);
    end
    tests_run++;
    if (n_disp !== int'(sys_i && sys == 32'd1)) begin
      tests_failed++;
      $display("FAIL disp_valid id=%0d got %0d pulses, exp %0d", iid, n_disp, sys_i && sys == 32'd1);
    end
    if (!bad) begin
      tests_run++;
      if (got_op !== e_op || got_imm !== e_imm) begin
        tests_failed++;
        $display("FAIL alu_sel id=%0d got op=%0d imm=%0d, exp op=%0d imm=%0d", iid, got_op, got_imm, e_op, e_imm);
      end
    end
    tests_run++;
    if (retired !== exp_retired) begin
      tests_failed++;
      $display("FAIL retired id=%0d got %0d, exp %0d", iid, retired, exp_retired);
    end
    tests_run++;
    if (halted !== exp_halt || imem_req !== !exp_halt || illegal !== bad) begin
      tests_failed++;
      $display("FAIL end_state id=%0d halted=%b imem_req=%b illegal=%b, exp halted=%b imem_req=%b illegal=%b",
               iid, halted, imem_req, illegal, exp_halt, !exp_halt, bad);
    end
  endtask

  task automatic test_reset();
    int n_req;
    do_reset();
    #1;
    tests_run++;
    if ({imem_req, ir_load, pc_inc, pc_load, reg_we, dst_ra, dmem_re, dmem_we, disp_valid, halted, illegal} !== 11'b0
        || retired !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state strobes=%b retired=%0d, exp all zero",
               {imem_req, ir_load, pc_inc, pc_load, reg_we, dst_ra, dmem_re, dmem_we, disp_valid, halted, illegal}, retired);
    end
    n_req = 0;
    imem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_req += int'(imem_req);
    end
    imem_ready = 1'b0;
    tests_run++;
    if (n_req !== 0) begin
      tests_failed++;
      $display("FAIL idle_no_start imem_req cycles=%0d, exp 0", n_req);
    end
    @(negedge clk);
    $display("[TB] reset and idle checked");
  endtask

  task automatic test_basic();
    go();
    run_instr(1, 1'b0, 32'd0, 0, 0);
    run_instr(13, 1'b0, 32'd0, 0, 3);
    run_instr(15, 1'b1, 32'd0, 0, 0);
    run_instr(15, 1'b0, 32'd0, 1, 0);
    run_instr(23, 1'b0, 32'd0, 0, 0);
    run_instr(14, 1'b0, 32'd0, 2, 0);
    run_instr(22, 1'b0, 32'd0, 0, 0);
  endtask

  task automatic test_random();
    int unsigned iid;
    logic [31:0] sys;
    do_reset();
    go();
    repeat (60) begin
      iid = $urandom_range(1, 26);
      sys = ($urandom % 2) ? 32'd1 : 32'($urandom_range(11, 1000));
      run_instr(iid, 1'($urandom % 2), sys, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_syscall_halt();
    int n_req;
    do_reset();
    go();
    run_instr(26, 1'b0, 32'd1, 1, 0);
    run_instr(26, 1'b0, 32'd10, 0, 0);
    n_req = 0;
    start = 1'b1; imem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_req += int'(imem_req);
    end
    start = 1'b0; imem_ready = 1'b0;
    tests_run++;
    if (halted !== 1'b1 || n_req !== 0) begin
      tests_failed++;
      $display("FAIL halt_ignores_start halted=%b req_cycles=%0d, exp halted=1 req_cycles=0", halted, n_req);
    end
    @(negedge clk);
    do_reset();
    #1;
    tests_run++;
    if (halted !== 1'b0 || imem_req !== 1'b0 || retired !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_from_halt halted=%b imem_req=%b retired=%0d, exp 0 0 0", halted, imem_req, retired);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    do_reset();
    go();
    run_instr(7, 1'b0, 32'd0, 0, 0);
    run_instr(27, 1'b0, 32'd0, 1, 0);
    @(negedge clk);
    do_reset();
    go();
    run_instr(0, 1'b0, 32'd0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    go();
    id = 32'd13; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (dmem_re !== 1'b1) begin
      tests_failed++;
      $display("FAIL mem_wait dmem_re=%b, exp 1", dmem_re);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (dmem_re !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0 || retired !== 32'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_mem dmem_re=%b imem_req=%b halted=%b retired=%0d, exp 0 0 0 0",
               dmem_re, imem_req, halted, retired);
    end
    @(negedge clk);
    rst = 1'b0;
    dmem_ready = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (imem_req !== 1'b0 || dmem_re !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_rst imem_req=%b dmem_re=%b, exp 0 0", imem_req, dmem_re);
    end
    dmem_ready = 1'b0;
    $display("[TB] reset during MEM wait checked");
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; exp_retired = '0;
    rst = 1'b1; start = 1'b0; id = 32'd0; br_taken = 1'b0; sys_sel = 32'd0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    init_ref();
    @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_syscall_halt();
    test_illegal();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
